pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, optional 2-entry skid buffer, flush-to-bubble and a stall/bubble statistics counter. It is the generic replacement for the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined RISC-V core. Each instance carries a PC, an instruction word and a flat control vector. Invalid slots always present a NOP instruction and all-zero control, so no write-enable can leak downstream.

---
 rtl/pipe_stage_skid_if.sv | 39 +++
 rtl/pipe_stage_skid.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid_if
// Brief    : Upstream/downstream handshake bundle for one pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_stage_skid_if #(
    parameter int PC_W   = 32,
    parameter int IR_W   = 32,
    parameter int CTRL_W = 16,
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [IR_W-1:0]   in_ir;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [IR_W-1:0]   out_ir;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  bubble_cnt;

    // master = the environment around the stage, slave = the stage itself
    modport master (
        output in_valid, in_pc, in_ir, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_ir, out_ctrl, out_data, bubble_cnt
    );
    modport slave (
        input  in_valid, in_pc, in_ir, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_pc, out_ir, out_ctrl, out_data, bubble_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Brief    : Valid/ready pipeline register with optional skid slot, flush and
//            bubble counter; invalid slots present NOP and zero control.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int              PC_W   = 32,
    parameter int              IR_W   = 32,
    parameter int              CTRL_W = 16,
    parameter int              DATA_W = 96,
    parameter int              SKID   = 1,
    parameter logic [IR_W-1:0] NOP_IR = IR_W'(32'h0000_0013),
    parameter int              CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    pipe_stage_skid_if.slave    bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              r_main_valid;
    logic [PC_W-1:0]   r_main_pc;
    logic [IR_W-1:0]   r_main_ir;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_pop;
    logic              w_load_main;
    logic              w_from_skid;
    logic              w_clear_main;
    logic [PC_W-1:0]   w_skid_pc;
    logic [IR_W-1:0]   w_skid_ir;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_pop    = r_main_valid && bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic              r_skid_valid;
            logic [PC_W-1:0]   r_skid_pc;
            logic [IR_W-1:0]   r_skid_ir;
            logic [CTRL_W-1:0] r_skid_ctrl;
            logic [DATA_W-1:0] r_skid_data;
            logic              w_load_skid;

            // Ready comes straight from a flop: no combinational ready path.
            assign w_in_ready   = !r_skid_valid;
            assign w_from_skid  = r_skid_valid && w_pop;
            assign w_load_main  = w_accept && (!r_main_valid || w_pop);
            assign w_load_skid  = w_accept && r_main_valid && !w_pop;
            assign w_clear_main = w_pop && !r_skid_valid && !w_accept;
            assign w_skid_pc    = r_skid_pc;
            assign w_skid_ir    = r_skid_ir;
            assign w_skid_ctrl  = r_skid_ctrl;
            assign w_skid_data  = r_skid_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_skid_valid <= 1'b0;
                    r_skid_pc    <= '0;
                    r_skid_ir    <= NOP_IR;
                    r_skid_ctrl  <= '0;
                    r_skid_data  <= '0;
                end else if (bus.flush || w_from_skid) begin
                    r_skid_valid <= 1'b0;
                    r_skid_ir    <= NOP_IR;
                    r_skid_ctrl  <= '0;
                end else if (w_load_skid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_pc    <= bus.in_pc;
                    r_skid_ir    <= bus.in_ir;
                    r_skid_ctrl  <= bus.in_ctrl;
                    r_skid_data  <= bus.in_data;
                end
            end
        end else begin : g_noskid
            assign w_in_ready   = !r_main_valid || bus.out_ready;
            assign w_from_skid  = 1'b0;
            assign w_load_main  = w_accept;
            assign w_clear_main = w_pop && !w_accept;
            assign w_skid_pc    = '0;
            assign w_skid_ir    = NOP_IR;
            assign w_skid_ctrl  = '0;
            assign w_skid_data  = '0;
        end
    endgenerate

    // Flush wins over everything; PC still follows the input for traceability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_ir    <= NOP_IR;
            r_main_ctrl  <= '0;
            r_main_data  <= '0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= bus.in_pc;
            r_main_ir    <= NOP_IR;
            r_main_ctrl  <= '0;
        end else if (w_from_skid) begin
            r_main_valid <= 1'b1;
            r_main_pc    <= w_skid_pc;
            r_main_ir    <= w_skid_ir;
            r_main_ctrl  <= w_skid_ctrl;
            r_main_data  <= w_skid_data;
        end else if (w_load_main) begin
            r_main_valid <= 1'b1;
            r_main_pc    <= bus.in_pc;
            r_main_ir    <= bus.in_ir;
            r_main_ctrl  <= bus.in_ctrl;
            r_main_data  <= bus.in_data;
        end else if (w_clear_main) begin
            r_main_valid <= 1'b0;
            r_main_ir    <= NOP_IR;
            r_main_ctrl  <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (bus.out_ready && !r_main_valid && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_main_valid;
    assign bus.out_pc     = r_main_pc;
    assign bus.out_ir     = r_main_ir;
    assign bus.out_ctrl   = r_main_ctrl;
    assign bus.out_data   = r_main_data;
    assign bus.bubble_cnt = r_bubble_cnt;
endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Brief    : Self-checking bench for pipe_stage_skid, SKID=1 and SKID=0 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;
    localparam logic [31:0] c_nop = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [15:0] ctrl;
        logic [95:0] data;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    total = 0;
    int    bad = 0;
    beat_t q1[$];
    beat_t q0[$];

    pipe_stage_skid_if #(.CNT_W(4)) bus1 ();
    pipe_stage_skid_if #(.CNT_W(4)) bus0 ();

    pipe_stage_skid #(.SKID(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    pipe_stage_skid #(.SKID(0), .CNT_W(4)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    always #5 clk = ~clk;

    // Scoreboards: push on accept, pop and compare on pop, drop all on flush/reset.
    always @(negedge clk) begin : mon1
        beat_t e;
        if (!rst_n || bus1.flush) begin
            q1.delete();
        end else begin
            if (bus1.out_valid && bus1.out_ready) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb1_extra got pc=%h required no beat", bus1.out_pc);
                end else begin
                    e = q1.pop_front();
                    if ({bus1.out_pc, bus1.out_ir, bus1.out_ctrl, bus1.out_data} !== e) begin
                        bad++;
                        $display("FAIL sb1_beat got pc=%h ir=%h ctrl=%h required pc=%h ir=%h ctrl=%h",
                                 bus1.out_pc, bus1.out_ir, bus1.out_ctrl, e.pc, e.ir, e.ctrl);
                    end
                end
            end
            if (bus1.in_valid && bus1.in_ready)
                q1.push_back({bus1.in_pc, bus1.in_ir, bus1.in_ctrl, bus1.in_data});
        end
    end

    always @(negedge clk) begin : mon0
        beat_t e;
        if (!rst_n || bus0.flush) begin
            q0.delete();
        end else begin
            if (bus0.out_valid && bus0.out_ready) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb0_extra got pc=%h required no beat", bus0.out_pc);
                end else begin
                    e = q0.pop_front();
                    if ({bus0.out_pc, bus0.out_ir, bus0.out_ctrl, bus0.out_data} !== e) begin
                        bad++;
                        $display("FAIL sb0_beat got pc=%h ir=%h ctrl=%h required pc=%h ir=%h ctrl=%h",
                                 bus0.out_pc, bus0.out_ir, bus0.out_ctrl, e.pc, e.ir, e.ctrl);
                    end
                end
            end
            if (bus0.in_valid && bus0.in_ready)
                q0.push_back({bus0.in_pc, bus0.in_ir, bus0.in_ctrl, bus0.in_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic [31:0] pc, input logic [15:0] ctrl);
        bus1.in_valid = v;
        bus1.in_pc    = pc;
        bus1.in_ir    = 32'hC000_0000 | pc;
        bus1.in_ctrl  = ctrl;
        bus1.in_data  = {pc, ~pc, pc ^ 32'h1234_5678};
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic [15:0] ctrl);
        bus0.in_valid = v;
        bus0.in_pc    = pc;
        bus0.in_ir    = 32'hC000_0000 | pc;
        bus0.in_ctrl  = ctrl;
        bus0.in_data  = {pc, ~pc, pc ^ 32'h1234_5678};
    endtask

    task automatic test_reset();
        drive1(1'b1, 32'h0, 16'h0);
        drive0(1'b1, 32'h0, 16'h0);
        bus1.flush = 1'b0; bus0.flush = 1'b0;
        bus1.out_ready = 1'b0; bus0.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({bus1.out_valid, bus1.out_ir, bus1.out_ctrl, bus1.bubble_cnt, bus1.in_ready}
            !== {1'b0, c_nop, 16'h0, 4'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset1 got v=%b ir=%h ctrl=%h cnt=%h rdy=%b required 0/00000013/0/0/1",
                     bus1.out_valid, bus1.out_ir, bus1.out_ctrl, bus1.bubble_cnt, bus1.in_ready);
        end
        total++;
        if ({bus0.out_valid, bus0.out_ir, bus0.out_ctrl, bus0.bubble_cnt, bus0.in_ready,
             bus0.out_pc, bus0.out_data} !== {1'b0, c_nop, 16'h0, 4'h0, 1'b1, 32'h0, 96'h0}) begin
            bad++;
            $display("FAIL reset0 got v=%b ir=%h ctrl=%h cnt=%h rdy=%b pc=%h required 0/00000013/0/0/1/0",
                     bus0.out_valid, bus0.out_ir, bus0.out_ctrl, bus0.bubble_cnt, bus0.in_ready, bus0.out_pc);
        end
        rst_n = 1'b1;
        drive1(1'b1, 32'h100, 16'h00FF);
        drive0(1'b0, 32'h0, 16'h0);
        tick();
        total++;
        if ({bus1.out_valid, bus1.out_pc, bus1.out_ctrl} !== {1'b1, 32'h100, 16'h00FF}) begin
            bad++;
            $display("FAIL first_beat got v=%b pc=%h ctrl=%h required 1/00000100/00ff",
                     bus1.out_valid, bus1.out_pc, bus1.out_ctrl);
        end
        drive1(1'b0, 32'h0, 16'h0);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_stream1();
        bus1.out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                total++;
                if ({bus1.out_valid, bus1.out_pc} !== {1'b1, 32'(4 * (i - 1))}) begin
                    bad++;
                    $display("FAIL stream1_out got v=%b pc=%h required 1/%h",
                             bus1.out_valid, bus1.out_pc, 32'(4 * (i - 1)));
                end
            end
            if (i < 8) begin
                drive1(1'b1, 32'(4 * i), 16'(4 * i) ^ 16'h5A5A);
                #1;
                total++;
                if (bus1.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream1_ready got %b required 1 at beat %0d", bus1.in_ready, i);
                end
            end else begin
                drive1(1'b0, 32'h0, 16'h0);
            end
            tick();
        end
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_stream0();
        bus0.out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                total++;
                if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'(4 * (i - 1))}) begin
                    bad++;
                    $display("FAIL stream0_out got v=%b pc=%h required 1/%h",
                             bus0.out_valid, bus0.out_pc, 32'(4 * (i - 1)));
                end
            end
            if (i < 8) begin
                drive0(1'b1, 32'(4 * i), 16'(4 * i) ^ 16'h5A5A);
                #1;
                total++;
                if (bus0.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream0_ready got %b required 1 at beat %0d", bus0.in_ready, i);
                end
            end else begin
                drive0(1'b0, 32'h0, 16'h0);
            end
            tick();
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_skid_fill();
        bus1.out_ready = 1'b0;
        drive1(1'b1, 32'h200, 16'h1111);
        tick();
        drive1(1'b1, 32'h204, 16'h2222);
        #1;
        total++;
        if (bus1.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL skid_accept_b got rdy=%b required 1", bus1.in_ready);
        end
        tick();
        drive1(1'b0, 32'h0, 16'h0);
        total++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_pc} !== {1'b0, 1'b1, 32'h200}) begin
            bad++;
            $display("FAIL skid_full got rdy=%b v=%b pc=%h required 0/1/00000200",
                     bus1.in_ready, bus1.out_valid, bus1.out_pc);
        end
        bus1.out_ready = 1'b1;
        tick();
        total++;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_pc} !== {1'b1, 1'b1, 32'h204}) begin
            bad++;
            $display("FAIL skid_drain got rdy=%b v=%b pc=%h required 1/1/00000204",
                     bus1.in_ready, bus1.out_valid, bus1.out_pc);
        end
        tick();
        total++;
        if (bus1.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL skid_empty got v=%b required 0", bus1.out_valid);
        end
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_flush1();
        bus1.out_ready = 1'b0;
        drive1(1'b1, 32'h300, 16'h3333);
        tick();
        drive1(1'b1, 32'h304, 16'h4444);
        tick();
        drive1(1'b1, 32'h308, 16'h5555);
        bus1.flush = 1'b1;
        #1;
        total++;
        if (bus1.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush1_ready_same got %b required 0", bus1.in_ready);
        end
        tick();
        bus1.flush = 1'b0;
        drive1(1'b0, 32'h0, 16'h0);
        total++;
        if ({bus1.out_valid, bus1.out_ctrl, bus1.out_ir, bus1.out_pc, bus1.in_ready}
            !== {1'b0, 16'h0, c_nop, 32'h308, 1'b1}) begin
            bad++;
            $display("FAIL flush1_bubble got v=%b ctrl=%h ir=%h pc=%h rdy=%b required 0/0/00000013/00000308/1",
                     bus1.out_valid, bus1.out_ctrl, bus1.out_ir, bus1.out_pc, bus1.in_ready);
        end
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus1.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush1_ghost got v=%b pc=%h required 0", bus1.out_valid, bus1.out_pc);
            end
        end
        bus1.out_ready = 1'b0;
    endtask

    task automatic test_backpressure0();
        bus0.out_ready = 1'b0;
        drive0(1'b1, 32'h400, 16'h6666);
        tick();
        drive0(1'b1, 32'h404, 16'h7777);
        #1;
        total++;
        if (bus0.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp0_stall got rdy=%b required 0", bus0.in_ready);
        end
        bus0.out_ready = 1'b1;
        #1;
        total++;
        if (bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp0_release got rdy=%b required 1", bus0.in_ready);
        end
        tick();
        drive0(1'b0, 32'h0, 16'h0);
        total++;
        if ({bus0.out_valid, bus0.out_pc, bus0.out_ctrl} !== {1'b1, 32'h404, 16'h7777}) begin
            bad++;
            $display("FAIL bp0_load got v=%b pc=%h ctrl=%h required 1/00000404/7777",
                     bus0.out_valid, bus0.out_pc, bus0.out_ctrl);
        end
        tick();
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_flush0();
        bus0.out_ready = 1'b0;
        drive0(1'b1, 32'h500, 16'h8888);
        tick();
        bus0.out_ready = 1'b1;
        drive0(1'b1, 32'h504, 16'h9999);
        bus0.flush = 1'b1;
        #1;
        total++;
        if (bus0.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush0_ready_same got %b required 1", bus0.in_ready);
        end
        tick();
        bus0.flush = 1'b0;
        drive0(1'b0, 32'h0, 16'h0);
        total++;
        if ({bus0.out_valid, bus0.out_ctrl, bus0.out_ir, bus0.out_pc}
            !== {1'b0, 16'h0, c_nop, 32'h504}) begin
            bad++;
            $display("FAIL flush0_bubble got v=%b ctrl=%h ir=%h pc=%h required 0/0/00000013/00000504",
                     bus0.out_valid, bus0.out_ctrl, bus0.out_ir, bus0.out_pc);
        end
        tick();
        total++;
        if (bus0.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush0_ghost got v=%b pc=%h required 0", bus0.out_valid, bus0.out_pc);
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_counter();
        logic [3:0] exp_cnt;
        drive1(1'b0, 32'h0, 16'h0);
        drive0(1'b0, 32'h0, 16'h0);
        bus1.out_ready = 1'b1;
        bus0.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({bus1.bubble_cnt, bus0.bubble_cnt} !== 8'h00) begin
            bad++;
            $display("FAIL cnt_reset got %h/%h required 0/0", bus1.bubble_cnt, bus0.bubble_cnt);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_cnt = (k > 15) ? 4'hF : 4'(k);
            total++;
            if ({bus1.bubble_cnt, bus0.bubble_cnt} !== {exp_cnt, exp_cnt}) begin
                bad++;
                $display("FAIL cnt_sat got %h/%h required %h at cycle %0d",
                         bus1.bubble_cnt, bus0.bubble_cnt, exp_cnt, k);
            end
        end
        bus1.out_ready = 1'b0;
        bus0.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream1();
        test_stream0();
        test_skid_fill();
        test_flush1();
        test_backpressure0();
        test_flush0();
        test_counter();
        total++;
        if ((q1.size() + q0.size()) != 0) begin
            bad++;
            $display("FAIL sb_leftover got %0d beats required 0", q1.size() + q0.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
